// File: rtl/truth_table_equiv_checker_pkg.sv
// rtl/truth_table_equiv_checker_pkg.sv - shared FSM encodings and parameter legality for the equivalence checker
package truth_table_equiv_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned N_VARS_MIN = 1;
  localparam int unsigned N_VARS_MAX = 8;

  function automatic bit n_vars_legal(input int unsigned n);
    return (n >= N_VARS_MIN) && (n <= N_VARS_MAX);
  endfunction

endpackage

// File: rtl/tt_sweep_counter.sv
// rtl/tt_sweep_counter.sv - index counter with clear/enable and an all-ones last flag
module tt_sweep_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] idx,
  output logic         last
);

  logic [W-1:0] idx_q;
  logic [W-1:0] idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (en) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx  = idx_q;
  assign last = &idx_q;

endmodule

// File: rtl/truth_table_equiv_checker.sv
// rtl/truth_table_equiv_checker.sv - sweeps all 2^N combinations comparing a reference and a simplified truth table
module truth_table_equiv_checker
  import truth_table_equiv_checker_pkg::*;
#(
  parameter  int unsigned N_VARS = 3,
  localparam int unsigned TT_W   = 1 << N_VARS,
  localparam int unsigned CNT_W  = N_VARS + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop_on_first,
  input  logic [TT_W-1:0]   tt_ref,
  input  logic [TT_W-1:0]   tt_dut,
  output logic              busy,
  output logic              done,
  output logic              equal,
  output logic [N_VARS-1:0] vec,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [N_VARS-1:0] first_bad,
  output logic              first_bad_vld,
  output logic [CNT_W-1:0]  zeros_ref
);

  if (!n_vars_legal(N_VARS)) begin : g_bad_n_vars
    $error("truth_table_equiv_checker: N_VARS must be in 1..8");
  end

  state_e            state_q, state_d;
  logic [TT_W-1:0]   ref_q, ref_d;
  logic [TT_W-1:0]   dut_q, dut_d;
  logic              stop_q, stop_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              equal_q, equal_d;
  logic [CNT_W-1:0]  mcnt_q, mcnt_d;
  logic [N_VARS-1:0] fbad_q, fbad_d;
  logic              fbv_q, fbv_d;
  logic [CNT_W-1:0]  zeros_q, zeros_d;

  logic              cnt_clr;
  logic              cnt_en;
  logic              cnt_last;
  logic [N_VARS-1:0] idx;
  logic              mm;
  logic              finish;

  tt_sweep_counter #(.W(N_VARS)) u_cnt (
    .clk  (clk),
    .rst  (reset),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .idx  (idx),
    .last (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    dut_d   = dut_q;
    stop_d  = stop_q;
    busy_d  = busy_q;
    done_d  = done_q;
    equal_d = equal_q;
    mcnt_d  = mcnt_q;
    fbad_d  = fbad_q;
    fbv_d   = fbv_q;
    zeros_d = zeros_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    mm      = ref_q[idx] ^ dut_q[idx];
    finish  = cnt_last || (mm && stop_q);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_SWEEP;
          ref_d   = tt_ref;
          dut_d   = tt_dut;
          stop_d  = stop_on_first;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          equal_d = 1'b0;
          mcnt_d  = '0;
          fbad_d  = '0;
          fbv_d   = 1'b0;
          zeros_d = '0;
          cnt_clr = 1'b1;
        end
      end
      ST_SWEEP: begin
        // Counters cannot exceed TT_W: at most one increment per index, and the sweep ends at TT_W-1.
        mcnt_d  = mcnt_q + {{(CNT_W-1){1'b0}}, mm};
        zeros_d = zeros_q + {{(CNT_W-1){1'b0}}, ~ref_q[idx]};
        if (mm && !fbv_q) begin
          fbad_d = idx;
          fbv_d  = 1'b1;
        end
        if (finish) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          equal_d = (mcnt_d == '0);
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ref_q   <= '0;
      dut_q   <= '0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      equal_q <= 1'b0;
      mcnt_q  <= '0;
      fbad_q  <= '0;
      fbv_q   <= 1'b0;
      zeros_q <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      dut_q   <= dut_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      equal_q <= equal_d;
      mcnt_q  <= mcnt_d;
      fbad_q  <= fbad_d;
      fbv_q   <= fbv_d;
      zeros_q <= zeros_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign equal         = equal_q;
  assign vec           = idx;
  assign mismatch_cnt  = mcnt_q;
  assign first_bad     = fbad_q;
  assign first_bad_vld = fbv_q;
  assign zeros_ref     = zeros_q;

endmodule

// File: tb/tb_truth_table_equiv_checker.sv
// tb/tb_truth_table_equiv_checker.sv - scoreboard bench for truth_table_equiv_checker at N_VARS 3, 1 and 8
module tb_truth_table_equiv_checker;

  typedef struct {
    int lat;
    int mcnt;
    int fb;
    int fbv;
    int zeros;
    int vec;
    int equal;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  logic         start3 = 0, stop3 = 0;
  logic [7:0]   ref3 = 0, dut3 = 0;
  logic         busy3, done3, equal3, fbv3;
  logic [2:0]   vec3, fb3;
  logic [3:0]   mcnt3, zeros3;

  logic         start1 = 0, stop1 = 0;
  logic [1:0]   ref1 = 0, dut1 = 0;
  logic         busy1, done1, equal1, fbv1;
  logic [0:0]   vec1, fb1;
  logic [1:0]   mcnt1, zeros1;

  logic         start8 = 0, stop8 = 0;
  logic [255:0] ref8 = 0, dut8 = 0;
  logic         busy8, done8, equal8, fbv8;
  logic [7:0]   vec8, fb8;
  logic [8:0]   mcnt8, zeros8;

  truth_table_equiv_checker #(.N_VARS(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .stop_on_first(stop3), .tt_ref(ref3), .tt_dut(dut3),
    .busy(busy3), .done(done3), .equal(equal3), .vec(vec3), .mismatch_cnt(mcnt3),
    .first_bad(fb3), .first_bad_vld(fbv3), .zeros_ref(zeros3));

  truth_table_equiv_checker #(.N_VARS(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .stop_on_first(stop1), .tt_ref(ref1), .tt_dut(dut1),
    .busy(busy1), .done(done1), .equal(equal1), .vec(vec1), .mismatch_cnt(mcnt1),
    .first_bad(fb1), .first_bad_vld(fbv1), .zeros_ref(zeros1));

  truth_table_equiv_checker #(.N_VARS(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .stop_on_first(stop8), .tt_ref(ref8), .tt_dut(dut8),
    .busy(busy8), .done(done8), .equal(equal8), .vec(vec8), .mismatch_cnt(mcnt8),
    .first_bad(fb8), .first_bad_vld(fbv8), .zeros_ref(zeros8));

  int sel = 3;
  int o_busy, o_done, o_equal, o_vec, o_mcnt, o_fb, o_fbv, o_zeros;

  always_comb begin
    o_busy = 0; o_done = 0; o_equal = 0; o_vec = 0; o_mcnt = 0; o_fb = 0; o_fbv = 0; o_zeros = 0;
    case (sel)
      1: begin
        o_busy = int'(busy1); o_done = int'(done1); o_equal = int'(equal1); o_vec = int'(vec1);
        o_mcnt = int'(mcnt1); o_fb = int'(fb1); o_fbv = int'(fbv1); o_zeros = int'(zeros1);
      end
      8: begin
        o_busy = int'(busy8); o_done = int'(done8); o_equal = int'(equal8); o_vec = int'(vec8);
        o_mcnt = int'(mcnt8); o_fb = int'(fb8); o_fbv = int'(fbv8); o_zeros = int'(zeros8);
      end
      default: begin
        o_busy = int'(busy3); o_done = int'(done3); o_equal = int'(equal3); o_vec = int'(vec3);
        o_mcnt = int'(mcnt3); o_fb = int'(fb3); o_fbv = int'(fbv3); o_zeros = int'(zeros3);
      end
    endcase
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int n, input logic [255:0] r, input logic [255:0] d, input bit s);
    exp_t e;
    e.mcnt = 0; e.fb = 0; e.fbv = 0; e.zeros = 0; e.vec = 0;
    for (int i = 0; i < (1 << n); i++) begin
      e.vec = i;
      if (r[i] == 1'b0) e.zeros++;
      if (r[i] != d[i]) begin
        e.mcnt++;
        if (e.fbv == 0) begin
          e.fb  = i;
          e.fbv = 1;
        end
        if (s) break;
      end
    end
    e.lat   = e.vec + 1;
    e.equal = (e.mcnt == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic set_in(input int w, input logic [255:0] r, input logic [255:0] d, input bit s, input bit st);
    case (w)
      1: begin ref1 = r[1:0]; dut1 = d[1:0]; stop1 = s; start1 = st; end
      8: begin ref8 = r; dut8 = d; stop8 = s; start8 = st; end
      default: begin ref3 = r[7:0]; dut3 = d[7:0]; stop3 = s; start3 = st; end
    endcase
  endtask

  // Accept a sweep, optionally re-pulse start with a corrupted tt_dut at cycle poke, then score the result.
  task automatic run(input string tag, input int w, input logic [255:0] r, input logic [255:0] d,
                     input bit s, input int poke);
    exp_t e;
    int cyc;
    sb.push_back(model(w, r, d, s));
    @(negedge clk);
    sel = w;
    set_in(w, r, d, s, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_in(w, r, d, s, 1'b0);
    chk({tag, "_busy_after_accept"}, o_busy, 1);
    cyc = 0;
    while (o_done == 0 && cyc < 400) begin
      if (cyc == poke) set_in(w, r, ~d, s, 1'b1);
      else if (cyc == poke + 1) set_in(w, r, ~d, s, 1'b0);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    set_in(w, r, d, s, 1'b0);
    chk({tag, "_done"}, o_done, 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_latency"}, cyc, e.lat);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_equal"}, o_equal, e.equal);
      chk({tag, "_mcnt"}, o_mcnt, e.mcnt);
      chk({tag, "_first_bad_vld"}, o_fbv, e.fbv);
      if (e.fbv != 0) chk({tag, "_first_bad"}, o_fb, e.fb);
      chk({tag, "_zeros"}, o_zeros, e.zeros);
      chk({tag, "_vec"}, o_vec, e.vec);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_equal"}, o_equal, 0);
    chk({tag, "_vec"}, o_vec, 0);
    chk({tag, "_mcnt"}, o_mcnt, 0);
    chk({tag, "_first_bad"}, o_fb, 0);
    chk({tag, "_first_bad_vld"}, o_fbv, 0);
    chk({tag, "_zeros"}, o_zeros, 0);
  endtask

  initial begin
    logic [255:0] rr, dd;
    sel = 3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst_in");
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst_out");

    run("t1_equal", 3, 256'h3E, 256'h3E, 1'b0, -1);
    chk("t1_zeros_const", o_zeros, 3);
    chk("t1_equal_const", o_equal, 1);
    run("t2_onebad", 3, 256'h3E, 256'h3C, 1'b0, -1);
    chk("t2_first_bad_const", o_fb, 1);
    chk("t2_mcnt_const", o_mcnt, 1);
    run("t3_allbad", 3, 256'h00, 256'hFF, 1'b0, -1);
    chk("t3_mcnt_const", o_mcnt, 8);
    chk("t3_zeros_const", o_zeros, 8);
    run("t3_stop", 3, 256'h00, 256'hFF, 1'b1, -1);
    chk("t3_stop_mcnt_const", o_mcnt, 1);
    run("t3_stop_k5", 3, 256'hA5, 256'h85, 1'b1, -1);
    chk("t3_stop_k5_vec_const", o_vec, 5);
    run("t4_restart_ignored", 3, 256'h95, 256'h95, 1'b0, 3);
    chk("t4_equal_const", o_equal, 1);

    // Reset during a sweep must discard everything.
    @(negedge clk);
    sel = 3;
    set_in(3, 256'h0F, 256'hF0, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_in(3, 256'h0F, 256'hF0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t5_busy_before_reset", o_busy, 1);
    reset = 1'b1;
    #1;
    chk_reset_vals("t5_mid_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("t5_after_reset");
    run("t5_clean", 3, 256'h0F, 256'hF0, 1'b0, -1);

    run("t6_n1", 1, 256'h2, 256'h3, 1'b0, -1);
    chk("t6_n1_mcnt_const", o_mcnt, 1);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 8; j++) begin
        rr[j*32 +: 32] = $urandom;
        dd[j*32 +: 32] = $urandom;
      end
      run($sformatf("t6_n8_rand%0d", k), 8, rr, dd, 1'b0, -1);
      chk($sformatf("t6_n8_popcount%0d", k), o_mcnt, $countones(rr ^ dd));
    end
    run("t6_n8_stop", 8, rr, dd, 1'b1, -1);
    run("t6_n8_equal", 8, rr, rr, 1'b0, -1);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
